// File: rtl/req_buffer.sv
// req_buffer: four per-channel request FIFOs feeding an arbiter, with one registered output slot and a sticky grant-error flag.
module req_buffer #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic [3:0]     req,
  input  logic [3:0]     gnt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_id,
  output logic           gnt_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0] head [4];
  logic [3:0] push, pop;
  logic multi, onehot, slot_free;
  logic [1:0] gidx;
  assign multi = (gnt & (gnt - 4'd1)) != 4'd0;
  assign onehot = gnt != 4'd0 && !multi;
  assign slot_free = !out_valid || out_ready;
  assign push = in_valid & in_ready;
  // req comes from registered counts only, so pop has no path from gnt back to req
  assign pop = (onehot && slot_free) ? (gnt & req) : 4'd0;
  assign gidx = {gnt[3] | gnt[2], gnt[3] | gnt[1]};
  for (genvar c = 0; c < 4; c++) begin : g_ch
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    assign in_ready[c] = cnt != FULL;
    assign req[c] = cnt != '0;
    assign head[c] = mem[rp];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push[c]) wp <= wp + AW'(1);
        if (pop[c]) rp <= rp + AW'(1);
        cnt <= cnt + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
      end
    always_ff @(posedge clk)
      if (push[c]) mem[wp] <= in_data[c*W +: W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= 2'd0;
      gnt_err <= 1'b0;
    end else begin
      if (pop != 4'd0) begin
        out_valid <= 1'b1;
        out_data <= head[gidx];
        out_id <= gidx;
      end else if (out_ready) out_valid <= 1'b0;
      if (multi) gnt_err <= 1'b1;
    end
endmodule
